// File: rtl/rgb565_to_gray.sv
// RGB565 to 8-bit BT.601 luma with 3-clk latency, sync delay, pixel/line position
// tracking, per-frame gray min/max and a sticky per-frame short/long line flag.
module rgb565_to_gray #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmos_frame_vsync,
    input  logic        cmos_frame_href,
    input  logic        cmos_frame_valid,
    input  logic [15:0] cmos_frame_data,
    output logic        gray_vsync,
    output logic        gray_href,
    output logic        gray_valid,
    output logic [7:0]  cmos_frame_Gray,
    output logic [10:0] gray_x,
    output logic [9:0]  gray_y,
    output logic        frame_done,
    output logic [7:0]  gray_min,
    output logic [7:0]  gray_max,
    output logic        line_err
);

    localparam logic [10:0] X_EXPECT = 11'(H_ACTIVE);
    localparam logic [10:0] X_SAT    = 11'h7FF;
    localparam logic [9:0]  Y_SAT    = 10'h3FF;

    generate
        if ((H_ACTIVE < 1) || (H_ACTIVE > 2047) || (V_ACTIVE < 1) || (V_ACTIVE > 1023)) begin : g_param_check
            $error("rgb565_to_gray: H_ACTIVE/V_ACTIVE outside the range of gray_x/gray_y");
        end
    endgenerate

    // Channel expansion by bit replication so full-scale inputs map to 255.
    logic [7:0] w_r8;
    logic [7:0] w_g8;
    logic [7:0] w_b8;

    assign w_r8 = {cmos_frame_data[15:11], cmos_frame_data[15:13]};
    assign w_g8 = {cmos_frame_data[10:5],  cmos_frame_data[10:9]};
    assign w_b8 = {cmos_frame_data[4:0],   cmos_frame_data[4:2]};

    logic [15:0] r_pr;
    logic [15:0] r_pg;
    logic [15:0] r_pb;
    logic [15:0] r_sum;
    logic [7:0]  r_gray;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pr   <= '0;
            r_pg   <= '0;
            r_pb   <= '0;
            r_sum  <= '0;
            r_gray <= '0;
        end else begin
            r_pr   <= {8'd0, w_r8} * 16'd77;
            r_pg   <= {8'd0, w_g8} * 16'd150;
            r_pb   <= {8'd0, w_b8} * 16'd29;
            r_sum  <= r_pr + r_pg + r_pb;
            r_gray <= 8'(r_sum >> 8);
        end
    end

    logic [2:0] r_vs_pipe;
    logic [2:0] r_hr_pipe;
    logic [2:0] r_va_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_pipe <= '0;
            r_hr_pipe <= '0;
            r_va_pipe <= '0;
        end else begin
            r_vs_pipe <= {r_vs_pipe[1:0], cmos_frame_vsync};
            r_hr_pipe <= {r_hr_pipe[1:0], cmos_frame_href};
            r_va_pipe <= {r_va_pipe[1:0], cmos_frame_valid};
        end
    end

    assign gray_vsync      = r_vs_pipe[2];
    assign gray_href       = r_hr_pipe[2];
    assign gray_valid      = r_va_pipe[2];
    assign cmos_frame_Gray = r_gray;

    logic r_vs_prev;
    logic r_hr_prev;
    logic w_vs_rise;
    logic w_hr_fall;
    logic w_line_end;
    logic w_line_bad;
    logic w_midline;
    logic w_pix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_prev <= 1'b0;
            r_hr_prev <= 1'b0;
        end else begin
            r_vs_prev <= gray_vsync;
            r_hr_prev <= gray_href;
        end
    end

    // A line only counts if it ended inside the frame; a line cut by vsync is
    // dropped and its trailing href fall (during blanking) is ignored.
    assign w_vs_rise  = gray_vsync & ~r_vs_prev;
    assign w_hr_fall  = r_hr_prev & ~gray_href;
    assign w_line_end = w_hr_fall & ~r_vs_prev;
    assign w_pix      = gray_valid & gray_href;
    assign w_midline  = w_vs_rise & gray_href;

    logic [10:0] r_x;
    logic [9:0]  r_y;

    assign w_line_bad = w_line_end & (r_x != X_EXPECT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
        end else if (w_hr_fall || w_vs_rise) begin
            r_x <= '0;
        end else if (w_pix && (r_x != X_SAT)) begin
            r_x <= r_x + 11'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y <= '0;
        end else if (w_vs_rise) begin
            r_y <= '0;
        end else if (w_line_end && (r_y != Y_SAT)) begin
            r_y <= r_y + 10'd1;
        end
    end

    assign gray_x = r_x;
    assign gray_y = r_y;

    logic [7:0] r_run_min;
    logic [7:0] r_run_max;
    logic [7:0] r_min;
    logic [7:0] r_max;
    logic [7:0] w_fold_min;
    logic [7:0] w_fold_max;

    // Running extremes including the pixel on the output this clk, so a final
    // pixel coinciding with the vsync rise still lands in its own frame.
    assign w_fold_min = (gray_valid && (r_gray < r_run_min)) ? r_gray : r_run_min;
    assign w_fold_max = (gray_valid && (r_gray > r_run_max)) ? r_gray : r_run_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_min <= 8'hFF;
            r_run_max <= 8'h00;
            r_min     <= 8'hFF;
            r_max     <= 8'h00;
        end else if (w_vs_rise) begin
            r_min     <= w_fold_min;
            r_max     <= w_fold_max;
            r_run_min <= 8'hFF;
            r_run_max <= 8'h00;
        end else if (gray_valid) begin
            r_run_min <= w_fold_min;
            r_run_max <= w_fold_max;
        end
    end

    assign gray_min = r_min;
    assign gray_max = r_max;

    logic r_frame_done;
    logic r_line_err;

    // frame_done follows the vsync rise by one clk so stats are already latched
    // while it is high; line_err still shows the finished frame during that clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_done <= 1'b0;
            r_line_err   <= 1'b0;
        end else begin
            r_frame_done <= w_vs_rise;
            if (r_frame_done) begin
                r_line_err <= 1'b0;
            end else if (w_line_bad || w_midline) begin
                r_line_err <= 1'b1;
            end
        end
    end

    assign frame_done = r_frame_done;
    assign line_err   = r_line_err;

endmodule

// File: tb/tb_rgb565_to_gray.sv
// Directed bench for rgb565_to_gray on a reduced 8x4 raster; an output monitor
// scores every gray_valid pixel for value, position and 3-clk latency.
module tb_rgb565_to_gray;

    localparam int H = 8;
    localparam int V = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] data = 16'h0000;
    logic        gray_vsync;
    logic        gray_href;
    logic        gray_valid;
    logic [7:0]  gray;
    logic [10:0] gray_x;
    logic [9:0]  gray_y;
    logic        frame_done;
    logic [7:0]  gray_min;
    logic [7:0]  gray_max;
    logic        line_err;

    rgb565_to_gray #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk              (clk),
        .rst              (rst),
        .cmos_frame_vsync (vsync),
        .cmos_frame_href  (href),
        .cmos_frame_valid (valid),
        .cmos_frame_data  (data),
        .gray_vsync       (gray_vsync),
        .gray_href        (gray_href),
        .gray_valid       (gray_valid),
        .cmos_frame_Gray  (gray),
        .gray_x           (gray_x),
        .gray_y           (gray_y),
        .frame_done       (frame_done),
        .gray_min         (gray_min),
        .gray_max         (gray_max),
        .line_err         (line_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] g;
        int         x;
        int         y;
        int         c;
    } exp_t;

    exp_t        q[$];
    logic [15:0] pix_buf[16];
    logic [7:0]  exp_buf[16];
    logic [7:0]  fmin;
    logic [7:0]  fmax;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_gray(input logic [15:0] d);
        int r, g, b, s;
        r = int'(d[15:11]);
        g = int'(d[10:5]);
        b = int'(d[4:0]);
        r = r * 8 + r / 4;
        g = g * 4 + g / 16;
        b = b * 8 + b / 4;
        s = r * 77 + g * 150 + b * 29;
        return 8'(s / 256);
    endfunction

    // Output monitor: one scoreboard entry per gray_valid pixel
    always @(negedge clk) begin
        if (!rst && gray_valid) begin
            chk("q_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                $display("pix cyc=%0d gray=%0d x=%0d y=%0d exp_gray=%0d exp_x=%0d exp_y=%0d",
                         cyc, gray, gray_x, gray_y, e.g, e.x, e.y);
                chk("gray", 32'(gray), 32'(e.g));
                chk("gray_x", 32'(gray_x), 32'(e.x));
                chk("gray_y", 32'(gray_y), 32'(e.y));
                chk("latency", 32'(cyc - e.c), 32'd3);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_buf(input int mode, input int line);
        for (int i = 0; i < H; i++) begin
            logic [4:0] k;
            k = 5'(((line * H + i) * 7) % 25 + 1);
            pix_buf[i] = (mode == 0) ? 16'($urandom) : {k, k, 1'b0, k};
            exp_buf[i] = ref_gray(pix_buf[i]);
        end
    endtask

    task automatic send_line(input int n, input bit gaps, input int line, input bit keep_href);
        for (int i = 0; i < n; i++) begin
            tick();
            href  = 1'b1;
            valid = 1'b1;
            data  = pix_buf[i];
            q.push_back('{g: exp_buf[i], x: i, y: line, c: cyc});
            if (exp_buf[i] < fmin) fmin = exp_buf[i];
            if (exp_buf[i] > fmax) fmax = exp_buf[i];
            if (gaps) begin
                tick();
                valid = 1'b0;
                data  = 16'($urandom);
            end
        end
        if (!keep_href) begin
            tick();
            href  = 1'b0;
            valid = 1'b0;
            repeat (4) tick();
        end
    endtask

    task automatic wait_frame_done(input string tag, input logic [7:0] emin,
                                   input logic [7:0] emax, input logic elerr);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        $display("%s frame_done=%0b min=%0d max=%0d line_err=%0b exp_min=%0d exp_max=%0d exp_lerr=%0b",
                 tag, seen, gray_min, gray_max, line_err, emin, emax, elerr);
        chk({tag, "_fd_seen"}, 32'(seen), 32'd1);
        chk({tag, "_min"}, 32'(gray_min), 32'(emin));
        chk({tag, "_max"}, 32'(gray_max), 32'(emax));
        chk({tag, "_lerr"}, 32'(line_err), 32'(elerr));
        chk({tag, "_y_clr"}, 32'(gray_y), 32'd0);
        @(negedge clk);
        chk({tag, "_fd_pulse"}, 32'(frame_done), 32'd0);
        chk({tag, "_lerr_clr"}, 32'(line_err), 32'd0);
    endtask

    task automatic run_frame(input string tag, input int mode, input bit gaps, input int short_line);
        fmin  = 8'hFF;
        fmax  = 8'h00;
        vsync = 1'b0;
        repeat (4) tick();
        for (int l = 0; l < V; l++) begin
            fill_buf(mode, l);
            send_line((l == short_line) ? H - 1 : H, gaps, l, 1'b0);
        end
        @(negedge clk);
        chk({tag, "_y_end"}, 32'(gray_y), 32'(V));
        chk({tag, "_lerr_pre"}, 32'(line_err), 32'(short_line >= 0));
        tick();
        vsync = 1'b1;
        wait_frame_done(tag, fmin, fmax, 1'(short_line >= 0));
    endtask

    task automatic check_reset(input string tag);
        $display("%s reset vs=%0b hr=%0b va=%0b gray=%0d x=%0d y=%0d fd=%0b min=%0h max=%0h lerr=%0b",
                 tag, gray_vsync, gray_href, gray_valid, gray, gray_x, gray_y,
                 frame_done, gray_min, gray_max, line_err);
        chk({tag, "_vsync"}, 32'(gray_vsync), 32'd0);
        chk({tag, "_href"}, 32'(gray_href), 32'd0);
        chk({tag, "_valid"}, 32'(gray_valid), 32'd0);
        chk({tag, "_gray"}, 32'(gray), 32'd0);
        chk({tag, "_x"}, 32'(gray_x), 32'd0);
        chk({tag, "_y"}, 32'(gray_y), 32'd0);
        chk({tag, "_fd"}, 32'(frame_done), 32'd0);
        chk({tag, "_min"}, 32'(gray_min), 32'hFF);
        chk({tag, "_max"}, 32'(gray_max), 32'h00);
        chk({tag, "_lerr"}, 32'(line_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check_reset("rst0");
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Known pixels with hand-computed grays; a 5-pixel line is also short
        fmin = 8'hFF;
        fmax = 8'h00;
        pix_buf[0] = 16'h0000; exp_buf[0] = 8'd0;
        pix_buf[1] = 16'hFFFF; exp_buf[1] = 8'd255;
        pix_buf[2] = 16'hF800; exp_buf[2] = 8'd76;
        pix_buf[3] = 16'h07E0; exp_buf[3] = 8'd149;
        pix_buf[4] = 16'h001F; exp_buf[4] = 8'd28;
        send_line(5, 1'b0, 0, 1'b0);
        @(negedge clk);
        chk("t1_y_end", 32'(gray_y), 32'd1);
        tick();
        vsync = 1'b1;
        wait_frame_done("t1", 8'd0, 8'd255, 1'b1);

        // Full frame, random pixels
        run_frame("t2", 0, 1'b0, -1);

        // Graded levels frame for min/max
        run_frame("t3", 1, 1'b0, -1);

        // One short line, then a clean frame shows the flag cleared
        run_frame("t4", 0, 1'b0, 2);
        run_frame("t4b", 1, 1'b0, -1);

        // vsync rising while href still high
        fmin  = 8'hFF;
        fmax  = 8'h00;
        vsync = 1'b0;
        repeat (4) tick();
        fill_buf(0, 0);
        send_line(H, 1'b0, 0, 1'b0);
        fill_buf(1, 1);
        send_line(3, 1'b0, 1, 1'b1);
        tick();
        valid = 1'b0;
        vsync = 1'b1;
        wait_frame_done("midl", fmin, fmax, 1'b1);
        tick();
        href = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("midl_y_after", 32'(gray_y), 32'd0);

        // Reset mid-line, then an empty frame and a full frame
        vsync = 1'b0;
        repeat (4) tick();
        fill_buf(0, 0);
        send_line(5, 1'b0, 0, 1'b1);
        tick();
        rst   = 1'b1;
        href  = 1'b0;
        valid = 1'b0;
        q.delete();
        @(negedge clk);
        check_reset("rst1");
        tick();
        @(negedge clk);
        check_reset("rst2");
        tick();
        rst   = 1'b0;
        vsync = 1'b1;
        wait_frame_done("t5_empty", 8'hFF, 8'h00, 1'b0);
        run_frame("t5", 1, 1'b0, -1);

        // Valid gaps inside href
        run_frame("t6", 0, 1'b1, -1);

        repeat (6) tick();
        chk("q_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
